mixcols: RTL and testbench
==========================

Name: mixcols

Overview:
- AES MixColumns round stage. Sits directly downstream of the ShiftRows stage in the round datapath.
- When the round controller enables it, it fetches the 128-bit state word from SRAM, transforms it one column per cycle, and writes the result back to the same address.
- Uses the same SRAM-master port set and enable/finished handshake as the neighbouring round stages, so the controller can sequence the stages uniformly.

Parameters:
- STATE_ADDR, 16'd32: SRAM address of the 128-bit AES state word.
- DUMP_NUM, 3'd2: constant value driven on sramDumpNum.
- INIT_NUM, 3'd1: constant value driven on sramInitNum.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- sramReadValue  in  128  SRAM read data; valid the cycle after sramRead is sampled.
- mixcols_enable  in  1  start/hold request from the round controller.
- mixcols_finished  out  1  operation complete; held while in DONE.
- sramWriteValue  out  128  transformed state word.
- sramRead  out  1  SRAM read strobe.
- sramWrite  out  1  SRAM write strobe.
- sramDump  out  1  tied 0 (owned by the controller).
- sramInit  out  1  tied 0.
- sramAddr  out  16  SRAM address.
- sramDumpNum  out  3  = DUMP_NUM.
- sramInitNum  out  3  = INIT_NUM.

Behaviour:
- Reset (async, n_rst=0):
  - State is IDLE.
  - All strobes are 0; mixcols_finished is 0; sramWriteValue is 0; sramAddr is 0.
  - Internal state register and column counter are 0.
- Byte order:
  - Byte k = bits [127-8k -: 8].
  - Column c = bytes 4c..4c+3, with row 0 first (FIPS-197 column-major).
- FSM states and transitions:
  - IDLE: if mixcols_enable=1, go to READ.
  - READ: sramRead=1, sramAddr=STATE_ADDR; go to LATCH.
  - LATCH: sramAddr stays STATE_ADDR; capture sramReadValue into the state register; colcnt=0; go to COMP.
  - COMP: replace column colcnt with its MixColumns result; colcnt++. After colcnt=3 is processed, go to WRITE. Exactly 4 cycles.
  - WRITE: sramWrite=1, sramAddr=STATE_ADDR, sramWriteValue=state register; go to DONE.
  - DONE: mixcols_finished=1; stay while mixcols_enable=1; go to IDLE when mixcols_enable=0.
- Latency:
  - Enable sampled in IDLE at edge 0.
  - sramRead is high during cycle 1.
  - sramWrite is high during cycle 7.
  - mixcols_finished rises at cycle 8.
- Column arithmetic over GF(2^8):
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 3x = xtime(x)^x. All operations are 8-bit with no carries.
- Output timing:
  - Strobes are registered or decoded from state, one cycle each, never both high together.
  - sramAddr = STATE_ADDR in READ, LATCH and WRITE; 0 otherwise.
  - sramWriteValue holds its last value outside WRITE.
- Boundary conditions:
  - Enable dropped mid-operation: the sequence runs to completion. DONE then lasts exactly one cycle and the FSM returns to IDLE.
  - Enable held high after DONE: no retrigger. A new run requires enable to go low and then high again.
  - Reset mid-operation: immediate return to IDLE with all outputs at reset values. No partial write occurs, because sramWrite clears asynchronously.
  - Columns outside the one currently being transformed are unmodified.

Optional Feature:
- Macro: INV_MIXCOLS_EN.
- Defined:
  - Adds input port mixcols_inverse (1 bit), sampled in IDLE when the operation starts and held for the whole run.
  - When it is 1, COMP applies InvMixColumns with coefficients 0E 0B 0D 09, built from chained xtime.
  - Latency and handshake are unchanged.
- Undefined: the port is absent and only the forward transform is synthesised.

Test Plan:
- Reset, then enable, with SRAM[32] = db135345_f20a225c_01010101_c6c6c6c6 -> SRAM[32] = 8e4da1bc_9fdc589d_01010101_c6c6c6c6. Finished rises 8 cycles after the enable sample.
- SRAM[32] = d4d4d4d5_2d26314c_00000000_ffffffff -> d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Enable held high for 20 cycles -> exactly one sramRead pulse and one sramWrite pulse; finished stays high until enable falls, then returns to 0 the next cycle.
- Enable deasserted at cycle 3 -> write still occurs at cycle 7 with the correct value; finished is high for exactly 1 cycle.
- n_rst pulsed low during COMP (cycle 4) -> all outputs go to 0 immediately, SRAM[32] is unchanged, and a subsequent enable produces the correct result.
- With INV_MIXCOLS_EN defined and mixcols_inverse=1, input 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6.

Source files
------------

// File: rtl/mixcols.sv
// AES MixColumns round stage.
// Fetches the 128-bit state word from SRAM, transforms it one column per
// cycle, and writes the result back to the same address. It uses the same
// enable/finished handshake as the neighbouring round stages.
// Optional feature macro: INV_MIXCOLS_EN adds the mixcols_inverse input,
// which selects InvMixColumns for a run.
module mixcols #(
   parameter logic [15:0] STATE_ADDR = 16'd32,
   parameter logic [2:0]  DUMP_NUM   = 3'd2,
   parameter logic [2:0]  INIT_NUM   = 3'd1
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [127:0] sramReadValue,
   input  logic         mixcols_enable,
`ifdef INV_MIXCOLS_EN
   input  logic         mixcols_inverse,
`endif
   output logic         mixcols_finished,
   output logic [127:0] sramWriteValue,
   output logic         sramRead,
   output logic         sramWrite,
   output logic         sramDump,
   output logic         sramInit,
   output logic [15:0]  sramAddr,
   output logic [2:0]   sramDumpNum,
   output logic [2:0]   sramInitNum
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      LATCH = 3'd2,
      COMP  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [127:0]  state_word;
   logic [127:0]  hold_value;
   logic [1:0]    colcnt;
   logic [6:0]    col_base;
   logic [31:0]   col_in;
   logic [31:0]   col_fwd;
   logic [31:0]   col_out;

   // GF(2^8) multiply by 2 with reduction by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // GF(2^8) multiply by 3.
   function automatic logic [7:0] mul3(input logic [7:0] b);
      mul3 = xtime(b) ^ b;
   endfunction

`ifdef INV_MIXCOLS_EN
   logic          inverse_run;
   logic [31:0]   col_inv;

   // Inverse coefficients are built from the x2, x4 and x8 multiples of a
   // byte, all obtained by chaining xtime.
   function automatic logic [7:0] mul9(input logic [7:0] b);
      mul9 = xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulB(input logic [7:0] b);
      mulB = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mulD(input logic [7:0] b);
      mulD = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mulE(input logic [7:0] b);
      mulE = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction
`endif

   // Select the column currently being transformed. Column c starts at bit
   // 127-32c, with row 0 in the most significant byte.
   always_comb begin
      col_base = 7'd127 - {colcnt, 5'd0};
      col_in   = state_word[col_base -: 32];
   end

   // Forward MixColumns of the selected column.
   always_comb begin
      col_fwd[31:24] = xtime(col_in[31:24]) ^ mul3(col_in[23:16]) ^ col_in[15:8] ^ col_in[7:0];
      col_fwd[23:16] = col_in[31:24] ^ xtime(col_in[23:16]) ^ mul3(col_in[15:8]) ^ col_in[7:0];
      col_fwd[15:8]  = col_in[31:24] ^ col_in[23:16] ^ xtime(col_in[15:8]) ^ mul3(col_in[7:0]);
      col_fwd[7:0]   = mul3(col_in[31:24]) ^ col_in[23:16] ^ col_in[15:8] ^ xtime(col_in[7:0]);
   end

`ifdef INV_MIXCOLS_EN
   // InvMixColumns of the selected column, and the choice of direction for
   // this run.
   always_comb begin
      col_inv[31:24] = mulE(col_in[31:24]) ^ mulB(col_in[23:16]) ^ mulD(col_in[15:8]) ^ mul9(col_in[7:0]);
      col_inv[23:16] = mul9(col_in[31:24]) ^ mulE(col_in[23:16]) ^ mulB(col_in[15:8]) ^ mulD(col_in[7:0]);
      col_inv[15:8]  = mulD(col_in[31:24]) ^ mul9(col_in[23:16]) ^ mulE(col_in[15:8]) ^ mulB(col_in[7:0]);
      col_inv[7:0]   = mulB(col_in[31:24]) ^ mulD(col_in[23:16]) ^ mul9(col_in[15:8]) ^ mulE(col_in[7:0]);
      col_out        = inverse_run ? col_inv : col_fwd;
   end

   // The direction is captured when a run starts so that a change on the
   // input mid-run cannot mix the two transforms within one state word.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         inverse_run <= 1'b0;
      end else if (state == IDLE && mixcols_enable) begin
         inverse_run <= mixcols_inverse;
      end
   end
`else
   // Only the forward transform exists in this build.
   always_comb begin
      col_out = col_fwd;
   end
`endif

   // Control state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. DONE waits for enable to drop, so holding enable high
   // cannot start a second run.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (mixcols_enable) next_state = READ;
         READ:    next_state = LATCH;
         LATCH:   next_state = COMP;
         COMP:    if (colcnt == 2'd3) next_state = WRITE;
         WRITE:   next_state = DONE;
         DONE:    if (!mixcols_enable) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Working copy of the state word: loaded from SRAM data in LATCH, then one
   // column replaced per COMP cycle while the other three stay untouched.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_word <= 128'd0;
         colcnt     <= 2'd0;
      end else begin
         case (state)
            LATCH: begin
               state_word <= sramReadValue;
               colcnt     <= 2'd0;
            end
            COMP: begin
               state_word[col_base -: 32] <= col_out;
               colcnt                     <= colcnt + 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Remember the last written word so the write data bus stays stable
   // between runs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hold_value <= 128'd0;
      end else if (state == WRITE) begin
         hold_value <= state_word;
      end
   end

   // Strobes and address are decoded from the state, so an asynchronous
   // reset clears them immediately and no partial write can happen.
   always_comb begin
      sramRead         = (state == READ);
      sramWrite        = (state == WRITE);
      mixcols_finished = (state == DONE);
      sramAddr         = (state == READ || state == LATCH || state == WRITE) ? STATE_ADDR : 16'd0;
      sramWriteValue   = (state == WRITE) ? state_word : hold_value;
      sramDump         = 1'b0;
      sramInit         = 1'b0;
      sramDumpNum      = DUMP_NUM;
      sramInitNum      = INIT_NUM;
   end

endmodule

// File: tb/tb_mixcols.sv
// Self-checking bench for mixcols: table of directed column vectors plus
// hand-written sequences for enable-hold, early enable drop and mid-run reset.
module tb_mixcols;

   typedef struct {
      string        name;
      logic [127:0] din;
      logic [127:0] dout;
      logic         inv;
   } vec_t;

   logic         clk;
   logic         n_rst;
   logic [127:0] sramReadValue;
   logic         mixcols_enable;
   logic         inverse_drive;
   logic         mixcols_finished;
   logic [127:0] sramWriteValue;
   logic         sramRead;
   logic         sramWrite;
   logic         sramDump;
   logic         sramInit;
   logic [15:0]  sramAddr;
   logic [2:0]   sramDumpNum;
   logic [2:0]   sramInitNum;

   logic [127:0] mem;
   logic [127:0] load_val;
   logic         load_req;
   int           cyc = 0;
   int           start = 0;
   int           compared = 0;
   int           mismatched = 0;

   mixcols dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .sramReadValue    (sramReadValue),
      .mixcols_enable   (mixcols_enable),
`ifdef INV_MIXCOLS_EN
      .mixcols_inverse  (inverse_drive),
`endif
      .mixcols_finished (mixcols_finished),
      .sramWriteValue   (sramWriteValue),
      .sramRead         (sramRead),
      .sramWrite        (sramWrite),
      .sramDump         (sramDump),
      .sramInit         (sramInit),
      .sramAddr         (sramAddr),
      .sramDumpNum      (sramDumpNum),
      .sramInitNum      (sramInitNum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used to time strobes relative to the
   // enable sample.
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model for the single state word; read data appears the cycle
   // after the read strobe is sampled.
   always @(posedge clk) begin
      if (load_req) begin
         mem <= load_val;
      end else if (sramWrite && sramAddr == 16'd32) begin
         mem <= sramWriteValue;
      end
      if (sramRead && sramAddr == 16'd32) begin
         sramReadValue <= mem;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic loadMem(input logic [127:0] value);
      @(negedge clk);
      load_val = value;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // One full run: enable is raised, then dropped during cycle drop_at
   // (counted from the enable sample at edge 0).
   task automatic applyStimulus(input string name, input logic [127:0] din, input logic [127:0] dout,
                                input logic inv, input int drop_at);
      int  rel;
      int  reads = 0;
      int  writes = 0;
      int  read_at = 0;
      int  write_at = 0;
      int  fin_first = 0;
      int  fin_last = 0;
      int  fin_len = 0;
      int  overlap = 0;
      int  bad_addr = 0;
      int  exp_len;
      int  exp_last;
      bit  done = 0;
      $display("[TB] run %s inverse=%0b drop_at=%0d", name, inv, drop_at);
      loadMem(din);
      mixcols_enable = 1'b1;
      inverse_drive  = inv;
      @(posedge clk);
      #1;
      start = cyc;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         rel = cyc - start + 1;
         if (sramRead) begin
            reads++;
            read_at = rel;
         end
         if (sramWrite) begin
            writes++;
            write_at = rel;
         end
         if (sramRead && sramWrite) overlap++;
         if ((sramRead || sramWrite) && sramAddr != 16'd32) bad_addr++;
         if (mixcols_finished) begin
            if (fin_first == 0) fin_first = rel;
            fin_last = rel;
            fin_len++;
         end else if (fin_first != 0) begin
            done = 1;
         end
         if (rel == drop_at) mixcols_enable = 1'b0;
      end
      mixcols_enable = 1'b0;
      exp_len  = (drop_at < 8) ? 1 : drop_at - 7;
      exp_last = (drop_at < 8) ? 8 : drop_at;
      checkOutput({name, " completed"}, 128'(done), 128'd1);
      checkOutput({name, " result"}, mem, dout);
      checkOutput({name, " read count"}, 128'(reads), 128'd1);
      checkOutput({name, " write count"}, 128'(writes), 128'd1);
      checkOutput({name, " read cycle"}, 128'(read_at), 128'd1);
      checkOutput({name, " write cycle"}, 128'(write_at), 128'd7);
      checkOutput({name, " finished rise"}, 128'(fin_first), 128'd8);
      checkOutput({name, " finished length"}, 128'(fin_len), 128'(exp_len));
      checkOutput({name, " finished last"}, 128'(fin_last), 128'(exp_last));
      checkOutput({name, " strobe overlap"}, 128'(overlap), 128'd0);
      checkOutput({name, " strobe address"}, 128'(bad_addr), 128'd0);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, " sramRead"}, 128'(sramRead), 128'd0);
      checkOutput({name, " sramWrite"}, 128'(sramWrite), 128'd0);
      checkOutput({name, " finished"}, 128'(mixcols_finished), 128'd0);
      checkOutput({name, " sramAddr"}, 128'(sramAddr), 128'd0);
      checkOutput({name, " sramWriteValue"}, sramWriteValue, 128'd0);
   endtask

   initial begin
      vec_t vecs[$];
      logic [127:0] v1_in;
      logic [127:0] v1_out;
      int           rel;
      int           writes_seen;

      v1_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      v1_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      vecs.push_back('{"fips", v1_in, v1_out, 1'b0});
      vecs.push_back('{"mixed", 128'hd4d4d4d5_2d26314c_00000000_ffffffff,
                       128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b0});
      vecs.push_back('{"unit", 128'h01000000_00010000_00000100_80000000,
                       128'h02010103_03020101_01030201_1b80809b, 1'b0});
`ifdef INV_MIXCOLS_EN
      vecs.push_back('{"inverse", v1_out, v1_in, 1'b1});
`endif

      mixcols_enable = 1'b0;
      inverse_drive  = 1'b0;
      load_req       = 1'b0;
      load_val       = 128'd0;
      mem            = 128'd0;
      sramReadValue  = 128'd0;
      n_rst          = 1'b1;
      #2;
      n_rst = 1'b0;
      #10;
      checkResetOutputs("reset");
      checkOutput("reset sramDump", 128'(sramDump), 128'd0);
      checkOutput("reset sramInit", 128'(sramInit), 128'd0);
      checkOutput("reset sramDumpNum", 128'(sramDumpNum), 128'd2);
      checkOutput("reset sramInitNum", 128'(sramInitNum), 128'd1);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].name, vecs[i].din, vecs[i].dout, vecs[i].inv, 9);
         checkOutput({vecs[i].name, " write value held"}, sramWriteValue, vecs[i].dout);
      end

      applyStimulus("hold20", v1_in, v1_out, 1'b0, 20);
      applyStimulus("drop3", v1_in, v1_out, 1'b0, 3);

      // Reset pulsed during the second COMP cycle: everything clears at once
      // and the stored word is left alone.
      $display("[TB] run reset-during-comp");
      loadMem(v1_in);
      mixcols_enable = 1'b1;
      @(posedge clk);
      #1;
      start = cyc;
      rel = 0;
      for (int i = 0; i < 10 && rel != 4; i++) begin
         @(negedge clk);
         rel = cyc - start + 1;
      end
      n_rst = 1'b0;
      mixcols_enable = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      n_rst = 1'b1;
      writes_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sramWrite) writes_seen++;
      end
      checkOutput("midreset no write", 128'(writes_seen), 128'd0);
      checkOutput("midreset memory", mem, v1_in);
      applyStimulus("after-reset", v1_in, v1_out, 1'b0, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
